// File: rtl/rs232_rx_fifo_pkg.sv
// Shared constants for the UART receive FIFO: bus widths, port addresses and
// the bus FSM state encoding.
package rs232_rx_fifo_pkg;

  localparam int ADDR_SIZE = 16;
  localparam int DATA_SIZE = 16;

  localparam logic [ADDR_SIZE-1:0] RS232_RX_FIFO_ADDR   = 16'hff04;
  localparam logic [ADDR_SIZE-1:0] RS232_RX_STATUS_ADDR = 16'hff05;

  typedef enum logic {
    RXF_IDLE = 1'b0,
    RXF_DONE = 1'b1
  } rxf_state_e;

  function automatic logic [DATA_SIZE-1:0] zext_byte(input logic [7:0] b);
    return {{(DATA_SIZE-8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/rs232_rx_fifo_mem.sv
// DEPTH x 8 byte storage for the receive FIFO: one synchronous write port,
// one asynchronous read port.
module rs232_rx_fifo_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rs232_rx_fifo.sv
// Receive FIFO between async_receiver and the system bus, read through the
// read_q/read_dn/halt handshake. Define RS232_RX_STATUS_EN to add a status port.
module rs232_rx_fifo
  import rs232_rx_fifo_pkg::*;
#(
  parameter int                   DEPTH          = 16,
  parameter logic [ADDR_SIZE-1:0] RX_FIFO_ADDR   = RS232_RX_FIFO_ADDR,
  parameter logic [ADDR_SIZE-1:0] RX_STATUS_ADDR = RS232_RX_STATUS_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_oe,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic [ADDR_SIZE-1:0]     addr_in,
  input  logic                     read_q,
  input  logic                     halt_q,
  output logic [ADDR_SIZE-1:0]     addr_out,
  output logic [DATA_SIZE-1:0]     data_out,
  output logic                     read_dn,
  output logic                     rw_halt_out,
  output logic                     rx_pending,
  output logic                     rx_overflow,
  output rxf_state_e               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
    $error("DEPTH must be a power of two >= 2");
  if (RX_STATUS_ADDR == RX_FIFO_ADDR)
    $error("RX_STATUS_ADDR must differ from RX_FIFO_ADDR");

  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  rxf_state_e           state, state_nxt;
  logic                 empty, full, fifo_hit, pop, push_ok, drop;
  logic                 bus_accept;
  logic [7:0]           rd_byte;
  logic [DATA_SIZE-1:0] data_r;
  logic [ADDR_SIZE-1:0] addr_r;
  logic                 read_dn_r, halt_r, overflow_r;
`ifdef RS232_RX_STATUS_EN
  logic                 stat_rd;
  logic [DATA_SIZE-1:0] status_word;
`endif

  // Bus handshake: a request is read_q=1 with a decoded addr_in, held by the
  // requester until read_dn=1. read_dn is a one-bus-cycle pulse with valid
  // addr_out/data_out; all outputs are zero otherwise so they can be OR-ed.
  always_comb begin
    empty      = (count == '0);
    full       = (count == (PTR_W+1)'(DEPTH));
    fifo_hit   = read_q && (addr_in == RX_FIFO_ADDR);
    pop        = clk_oe && (state == RXF_IDLE) && fifo_hit && !empty;
    push_ok    = rx_valid && (!full || pop);
    drop       = rx_valid && full && !pop;
    bus_accept = pop;
`ifdef RS232_RX_STATUS_EN
    stat_rd     = clk_oe && (state == RXF_IDLE) && read_q &&
                  (addr_in == RX_STATUS_ADDR);
    status_word = DATA_SIZE'({count, overflow_r, full, empty});
    bus_accept  = pop || stat_rd;
`endif
  end

  always_comb begin
    state_nxt = state;
    if (clk_oe) begin
      case (state)
        RXF_IDLE: if (bus_accept) state_nxt = RXF_DONE;
        RXF_DONE: state_nxt = RXF_IDLE;
        default:  state_nxt = RXF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RXF_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      read_dn_r  <= 1'b0;
      halt_r     <= 1'b0;
      overflow_r <= 1'b0;
      data_r     <= '0;
      addr_r     <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
      if (clk_oe) begin
        read_dn_r <= (state == RXF_DONE);
        if (pop) begin
          data_r <= zext_byte(rd_byte);
          addr_r <= addr_in;
        end
`ifdef RS232_RX_STATUS_EN
        if (stat_rd) begin
          data_r <= status_word;
          addr_r <= addr_in;
        end
`endif
      end else begin
        halt_r <= (state == RXF_IDLE) && fifo_hit && empty;
      end
`ifdef RS232_RX_STATUS_EN
      if (stat_rd) overflow_r <= 1'b0;
`endif
      // A byte lost on the same edge as a status read stays reported.
      if (drop) overflow_r <= 1'b1;
    end
  end

  rs232_rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we      (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_byte)
  );

  assign read_dn     = read_dn_r;
  assign addr_out    = read_dn_r ? addr_r : '0;
  assign data_out    = read_dn_r ? data_r : '0;
  assign rw_halt_out = halt_q && halt_r;
  assign rx_pending  = !empty;
  assign rx_overflow = overflow_r;
  assign dbg_state   = state;
  assign dbg_count   = count;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Self-checking bench for rs232_rx_fifo: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_rs232_rx_fifo;
  import rs232_rx_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic                 clk, rst, clk_oe;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] addr_in;
  logic                 read_q, halt_q;
  logic [ADDR_SIZE-1:0] addr_out;
  logic [DATA_SIZE-1:0] data_out;
  logic                 read_dn, rw_halt_out, rx_pending, rx_overflow;
  rxf_state_e           dbg_state;
  logic [4:0]           dbg_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf;

  rs232_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .rx_data(rx_data),
    .rx_valid(rx_valid), .addr_in(addr_in), .read_q(read_q),
    .halt_q(halt_q), .addr_out(addr_out), .data_out(data_out),
    .read_dn(read_dn), .rw_halt_out(rw_halt_out), .rx_pending(rx_pending),
    .rx_overflow(rx_overflow), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // clock/reset block: clk_oe flips on falling edges, so rising edges
  // alternate between bus-phase (clk_oe=1) and halt-phase (clk_oe=0)
  initial begin
    clk = 1'b0;
    clk_oe = 1'b0;
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
      clk_oe = ~clk_oe;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    read_q = 1'b0;
    rx_valid = 1'b0;
    addr_in = '0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
  endtask

  task automatic align_oe();
    do begin
      @(negedge clk);
      #1;
    end while (clk_oe !== 1'b1);
  endtask

  task automatic wait_done(output logic [DATA_SIZE-1:0] d, output logic [ADDR_SIZE-1:0] a);
    bit got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (read_dn) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL read_timeout: read_dn never rose within 100 cycles");
    end
    d = data_out;
    a = addr_out;
    read_q = 1'b0;
    addr_in = '0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [ADDR_SIZE-1:0] addr,
                          output logic [DATA_SIZE-1:0] d, output logic [ADDR_SIZE-1:0] a);
    @(negedge clk);
    addr_in = addr;
    read_q = 1'b1;
    wait_done(d, a);
  endtask

  typedef struct {
    logic       is_read;
    logic [7:0] push_data;
    logic [7:0] exp_data;
    logic       exp_pending;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [DATA_SIZE-1:0] d;
    logic [ADDR_SIZE-1:0] a;

    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; addr_in = '0;
    read_q = 1'b0; halt_q = 1'b1;

    vecs[0] = '{1'b0, 8'h41, 8'h00, 1'b1};
    vecs[1] = '{1'b1, 8'h00, 8'h41, 1'b0};
    vecs[2] = '{1'b0, 8'hc3, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 8'h07, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 8'h00, 8'hc3, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'h07, 1'b0};
    vecs[6] = '{1'b0, 8'hff, 8'h00, 1'b1};

    // reset held 3 cycles
    do_reset();
    check("rst_read_dn", read_dn, 0);
    check("rst_data_out", data_out, 0);
    check("rst_addr_out", addr_out, 0);
    check("rst_halt", rw_halt_out, 0);
    check("rst_pending", rx_pending, 0);
    check("rst_overflow", rx_overflow, 0);
    check("rst_count", dbg_count, 0);
    check("rst_state", dbg_state, RXF_IDLE);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_read) begin
        bus_read(RS232_RX_FIFO_ADDR, d, a);
        check("tbl_data", d, {8'h00, vecs[i].exp_data});
        check("tbl_addr", a, RS232_RX_FIFO_ADDR);
        check("tbl_idle_zero", data_out | addr_out, 0);
      end else begin
        push_byte(vecs[i].push_data);
      end
      check("tbl_pending", rx_pending, vecs[i].exp_pending);
    end
    bus_read(RS232_RX_FIFO_ADDR, d, a);
    check("tbl_last", d, 16'h00ff);

    // empty read stalls until a byte arrives
    @(negedge clk);
    addr_in = RS232_RX_FIFO_ADDR;
    read_q = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("empty_halt", rw_halt_out, 1);
    check("empty_no_dn", read_dn, 0);
    halt_q = 1'b0;
    #1;
    check("halt_q_gate", rw_halt_out, 0);
    halt_q = 1'b1;
    push_byte(8'h5a);
    wait_done(d, a);
    check("empty_data", d, 16'h005a);
    check("empty_halt_clear", rw_halt_out, 0);
    check("empty_pending", rx_pending, 0);

    // fill to full, then push on the same edge as a pop
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    check("full_count", dbg_count, DEPTH);
    check("full_no_ovf", rx_overflow, 0);
    align_oe();
    addr_in = RS232_RX_FIFO_ADDR;
    read_q = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h99;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    check("simul_count", dbg_count, DEPTH);
    check("simul_no_ovf", rx_overflow, 0);
    wait_done(d, a);
    check("simul_data", d, 16'h0000);

    push_byte(8'h10);
    check("ovf_set", rx_overflow, 1);
    check("ovf_count", dbg_count, DEPTH);

`ifdef RS232_RX_STATUS_EN
    bus_read(RS232_RX_STATUS_ADDR, d, a);
    check("status1", d, {8'h00, 5'd16, 1'b1, 1'b1, 1'b0});
    check("status_addr", a, RS232_RX_STATUS_ADDR);
    bus_read(RS232_RX_STATUS_ADDR, d, a);
    check("status2", d, {8'h00, 5'd16, 1'b0, 1'b1, 1'b0});
    check("status_ovf_clr", rx_overflow, 0);
`else
    check("ovf_sticky", rx_overflow, 1);
`endif

    for (int i = 1; i < DEPTH; i++) begin
      bus_read(RS232_RX_FIFO_ADDR, d, a);
      check("wrap_order", d, 16'(i));
    end
    bus_read(RS232_RX_FIFO_ADDR, d, a);
    check("wrap_last_99", d, 16'h0099);
    check("wrap_empty", rx_pending, 0);

    // reset aborts a read in DONE and discards contents
    push_byte(8'h11);
    push_byte(8'h22);
    align_oe();
    addr_in = RS232_RX_FIFO_ADDR;
    read_q = 1'b1;
    @(negedge clk);
    #1;
    check("abort_in_done", dbg_state, RXF_DONE);
    rst = 1'b1;
    read_q = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("abort_no_dn", read_dn, 0);
    check("abort_pending", rx_pending, 0);
    check("abort_count", dbg_count, 0);
    check("abort_ovf", rx_overflow, 0);

    // randomized run against the queue model
    do_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (exp_q.size() == 0 || r < ((it < 150) ? 7 : 3)) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        push_byte(b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        bus_read(RS232_RX_FIFO_ADDR, d, a);
        check("rnd_data", d, {8'h00, e});
        check("rnd_addr", a, RS232_RX_FIFO_ADDR);
      end
      check("rnd_count", dbg_count, exp_q.size());
      check("rnd_pending", rx_pending, exp_q.size() != 0);
      check("rnd_ovf", rx_overflow, exp_ovf);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
